// File: rtl/sdram_addr_gen_defs.sv
// Shared definitions for the SDRAM burst address generator: FSM state
// encodings, default widths and the direction encoding.
package sdram_addr_gen_defs;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LEN_W = 4;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/addr_step_adder.sv
// Combinational WIDTH-bit adder with carry in/out. Subtraction is done by the
// caller feeding ~b and cin=1, so a cleared carry-out then means a borrow.
module addr_step_adder
  import sdram_addr_gen_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign sum_o    = full_sum[WIDTH-1:0];
  assign cout_o   = full_sum[WIDTH];

endmodule

// File: rtl/sdram_burst_addr_gen.sv
// Burst column-address sequencer: issues base, base+/-stride, ... for
// burst_len beats under a valid/ready handshake, feeding each sum back as the
// next operand. Optional macro SDRAM_ADDR_GEN_ABORT_EN adds an abort input
// that ends the burst early (default build: no abort port).
module sdram_burst_addr_gen
  import sdram_addr_gen_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [WIDTH-1:0] stride,
  input  logic             dir,
  input  logic [LEN_W-1:0] burst_len,
`ifdef SDRAM_ADDR_GEN_ABORT_EN
  input  logic             abort,
`endif
  input  logic             addr_ready,
  output logic [WIDTH-1:0] addr_out,
  output logic             addr_valid,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t            state_q,  state_d;
  logic [WIDTH-1:0]  addr_q,   addr_d;
  logic [WIDTH-1:0]  stride_q, stride_d;
  logic              dir_q,    dir_d;
  logic [LEN_W-1:0]  len_q,    len_d;
  logic [LEN_W-1:0]  count_q,  count_d;
  logic              wrap_q,   wrap_d;

  logic              abort_w;
  logic [WIDTH-1:0]  step_sum;
  logic              step_cout;
  logic              step_wrap;

`ifdef SDRAM_ADDR_GEN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Decrement is addr + ~stride + 1; carry-out low then signals a borrow.
  addr_step_adder #(.WIDTH(WIDTH)) u_step (
    .a_i    (addr_q),
    .b_i    ((dir_q == DIR_DEC) ? ~stride_q : stride_q),
    .cin_i  (dir_q == DIR_DEC),
    .sum_o  (step_sum),
    .cout_o (step_cout)
  );

  assign step_wrap = (dir_q == DIR_DEC) ? ~step_cout : step_cout;

  // Outputs come straight from registers: no path from addr_ready.
  assign addr_out   = addr_q;
  assign addr_valid = (state_q == ISSUE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign wrap       = wrap_q;

  // Next-state and datapath update for the IDLE/ISSUE/DONE sequence.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    dir_d    = dir_q;
    len_d    = len_q;
    count_d  = count_q;
    wrap_d   = wrap_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (burst_len != '0) begin
            stride_d = stride;
            dir_d    = dir;
            len_d    = burst_len;
            addr_d   = base_addr;
            count_d  = '0;
            wrap_d   = 1'b0;
            state_d  = ISSUE;
          end else begin
            state_d  = DONE;
          end
        end
      end
      ISSUE: begin
        if (addr_ready) begin
          count_d = count_q + LEN_W'(1);
          if (count_q == len_q - LEN_W'(1)) begin
            state_d = DONE;
          end else if (!abort_w) begin
            // Only steps whose result is actually issued may set wrap.
            addr_d = step_sum;
            if (step_wrap) wrap_d = 1'b1;
          end
        end
        if (abort_w) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      dir_q    <= DIR_INC;
      len_q    <= '0;
      count_q  <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      dir_q    <= dir_d;
      len_q    <= len_d;
      count_q  <= count_d;
      wrap_q   <= wrap_d;
    end
  end

endmodule

// File: tb/tb_sdram_burst_addr_gen.sv
// Self-checking bench for sdram_burst_addr_gen: table-driven bursts,
// hand-written corner sequences and randomized bursts against a model.
module tb_sdram_burst_addr_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [7:0] stride;
  logic       dir;
  logic [3:0] burst_len;
  logic       abort;
  logic       addr_ready;
  logic [7:0] addr_out;
  logic       addr_valid;
  logic       busy;
  logic       done;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  sdram_burst_addr_gen #(.WIDTH(8), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .stride     (stride),
    .dir        (dir),
    .burst_len  (burst_len),
`ifdef SDRAM_ADDR_GEN_ABORT_EN
    .abort      (abort),
`endif
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .busy       (busy),
    .done       (done),
    .wrap       (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] base;
    logic [7:0] stride;
    logic       dir;
    logic [3:0] len;
    int         exp_n;
    logic [7:0] exp_last;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[8];

  // Results of the most recent burst.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       exp_wrap;
  logic       got_wrap;
  logic       got_first_valid;
  logic [7:0] got_first_addr;
  int         got_cycles;
  bit         got_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: address k is base +/- k*stride mod 256; wrap is set if any
  // issued step (k >= 1) crossed the 0/255 boundary.
  function automatic void model(input logic [7:0] b, input logic [7:0] s,
                                input logic d, input int l);
    int a;
    int si;
    a  = int'(b);
    si = int'(s);
    exp_q.delete();
    exp_wrap = 1'b0;
    for (int k = 0; k < l; k++) begin
      exp_q.push_back(8'(a));
      if (k < l - 1) begin
        if (!d) begin
          if (a + si > 255) exp_wrap = 1'b1;
          a = (a + si) % 256;
        end else begin
          if (a < si) exp_wrap = 1'b1;
          a = (a - si + 256) % 256;
        end
      end
    end
  endfunction

  // Starts a burst in the current (IDLE) cycle and collects handshakes until
  // done, then steps into the following IDLE cycle.
  task automatic run_burst(input logic [7:0] b, input logic [7:0] s, input logic d,
                           input logic [3:0] l, input bit rnd_ready);
    int cyc;
    got_q.delete();
    got_done        = 1'b0;
    got_first_valid = 1'b0;
    got_first_addr  = 8'h00;
    start     = 1'b1;
    base_addr = b;
    stride    = s;
    dir       = d;
    burst_len = l;
    tick();
    start     = 1'b0;
    base_addr = 8'($urandom);
    stride    = 8'($urandom);
    dir       = 1'($urandom);
    burst_len = 4'($urandom);
    cyc = 0;
    while (!got_done && cyc < 300) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        addr_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (cyc == 0) begin
          got_first_valid = addr_valid;
          got_first_addr  = addr_out;
        end
        if (addr_valid && addr_ready) got_q.push_back(addr_out);
        tick();
        cyc++;
      end
    end
    got_cycles = cyc;
    got_wrap   = wrap;
    chk("done_seen", 32'(got_done), 32'd1);
    addr_ready = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    vecs[0] = '{8'hAC, 8'h01, 1'b0, 4'd4,  4,  8'hAF, 1'b0};
    vecs[1] = '{8'h02, 8'h01, 1'b1, 4'd4,  4,  8'hFF, 1'b1};
    vecs[2] = '{8'hF0, 8'h08, 1'b0, 4'd3,  3,  8'h00, 1'b1};
    vecs[3] = '{8'h10, 8'h04, 1'b0, 4'd3,  3,  8'h18, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 1'b1, 4'd2,  2,  8'h00, 1'b0};
    vecs[5] = '{8'h80, 8'h40, 1'b1, 4'd15, 15, 8'h00, 1'b1};
    vecs[6] = '{8'hFE, 8'h01, 1'b0, 4'd1,  1,  8'hFE, 1'b0};
    vecs[7] = '{8'hFF, 8'hFF, 1'b0, 4'd2,  2,  8'hFE, 1'b1};

    rst_n = 1'b0; start = 1'b0; base_addr = 8'h00; stride = 8'h00;
    dir = 1'b0; burst_len = 4'd0; abort = 1'b0; addr_ready = 1'b1;
    tick(); tick();
    chk("rst_addr", 32'(addr_out), 32'h0);
    chk("rst_valid", 32'(addr_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven bursts with ready held high; back-to-back starts.
    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].base, vecs[i].stride, vecs[i].dir, vecs[i].len, 1'b0);
      $display("vec %0d: base=%02h stride=%02h dir=%0d len=%0d issued=%0d wrap=%0d",
               i, vecs[i].base, vecs[i].stride, vecs[i].dir, vecs[i].len, got_q.size(), got_wrap);
      chk("vec_first_valid", 32'(got_first_valid), 32'd1);
      chk("vec_first_addr", 32'(got_first_addr), 32'(vecs[i].base));
      chk("vec_count", 32'(got_q.size()), 32'(vecs[i].exp_n));
      chk("vec_cycles", 32'(got_cycles), 32'(vecs[i].exp_n));
      if (got_q.size() > 0) chk("vec_last", 32'(got_q[got_q.size() - 1]), 32'(vecs[i].exp_last));
      chk("vec_wrap", 32'(got_wrap), 32'(vecs[i].exp_wrap));
      model(vecs[i].base, vecs[i].stride, vecs[i].dir, int'(vecs[i].len));
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
        chk("vec_seq", 32'(got_q[k]), 32'(exp_q[k]));
    end

    // Zero length: done at T+1, no address issued.
    run_burst(8'h33, 8'h01, 1'b0, 4'd0, 1'b0);
    $display("len0: issued=%0d cycles=%0d", got_q.size(), got_cycles);
    chk("len0_count", 32'(got_q.size()), 32'd0);
    chk("len0_cycles", 32'(got_cycles), 32'd0);

    // Backpressure: ready low for two cycles on the first beat.
    start = 1'b1; base_addr = 8'h10; stride = 8'h04; dir = 1'b0; burst_len = 4'd3;
    tick();
    start = 1'b0;
    addr_ready = 1'b0;
    chk("bp_hold0", 32'({addr_valid, addr_out}), 32'h110);
    tick();
    chk("bp_hold1", 32'({addr_valid, addr_out}), 32'h110);
    tick();
    addr_ready = 1'b1;
    chk("bp_hold2", 32'({addr_valid, addr_out}), 32'h110);
    tick();
    chk("bp_beat2", 32'({addr_valid, addr_out}), 32'h114);
    tick();
    chk("bp_beat3", 32'({addr_valid, addr_out}), 32'h118);
    tick();
    chk("bp_done", 32'({done, addr_valid}), 32'b10);
    tick();
    chk("bp_idle", 32'({busy, done}), 32'b00);
    $display("backpressure sequence complete");

    // Start while busy must not disturb the running burst.
    start = 1'b1; base_addr = 8'hAC; stride = 8'h01; dir = 1'b0; burst_len = 4'd4;
    tick();
    base_addr = 8'h55; burst_len = 4'd2;
    got_q.delete();
    for (int c = 0; c < 4; c++) begin
      if (addr_valid) got_q.push_back(addr_out);
      tick();
    end
    start = 1'b0;
    chk("busy_start_done", 32'(done), 32'd1);
    chk("busy_start_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      chk("busy_start_a1", 32'(got_q[1]), 32'hAD);
      chk("busy_start_a3", 32'(got_q[3]), 32'hAF);
    end
    tick();
    $display("start-while-busy: issued=%0d", got_q.size());

    // Asynchronous reset mid-burst, after wrap has been set.
    start = 1'b1; base_addr = 8'hFE; stride = 8'h01; dir = 1'b0; burst_len = 4'd8;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_addr", 32'(addr_out), 32'h01);
    chk("pre_rst_wrap", 32'(wrap), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_addr", 32'(addr_out), 32'h0);
    chk("arst_flags", 32'({addr_valid, busy, done, wrap}), 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'({busy, addr_valid}), 32'b00);
    run_burst(8'h40, 8'h02, 1'b1, 4'd3, 1'b0);
    $display("after reset: issued=%0d", got_q.size());
    chk("post_rst_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) chk("post_rst_last", 32'(got_q[2]), 32'h3C);

`ifdef SDRAM_ADDR_GEN_ABORT_EN
    // Abort during beat 3 with ready high: three addresses, then done.
    start = 1'b1; base_addr = 8'h00; stride = 8'h01; dir = 1'b0; burst_len = 4'd8;
    tick();
    start = 1'b0;
    got_q.delete();
    for (int c = 0; c < 3; c++) begin
      abort = (c == 2);
      if (addr_valid) got_q.push_back(addr_out);
      tick();
    end
    abort = 1'b0;
    chk("abort_done", 32'({done, addr_valid}), 32'b10);
    chk("abort_count", 32'(got_q.size()), 32'd3);
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    $display("abort: issued=%0d", got_q.size());
`endif

    // Randomized bursts with random backpressure against the model.
    for (int r = 0; r < 40; r++) begin
      logic [7:0] rb;
      logic [7:0] rs;
      logic       rd;
      logic [3:0] rl;
      rb = 8'($urandom);
      rs = 8'($urandom_range(0, 255));
      rd = 1'($urandom);
      rl = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_burst(rb, rs, rd, rl, 1'b1);
      model(rb, rs, rd, int'(rl));
      $display("rand %0d: base=%02h stride=%02h dir=%0d len=%0d issued=%0d wrap=%0d",
               r, rb, rs, rd, rl, got_q.size(), got_wrap);
      chk("rand_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
        chk("rand_seq", 32'(got_q[k]), 32'(exp_q[k]));
      if (rl != 4'd0) chk("rand_wrap", 32'(got_wrap), 32'(exp_wrap));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
